// File: rtl/svc_rv_mem_arb.sv
// Two-port (instruction/data) arbiter onto one single-cycle-latency memory port.
// Data wins contention until it has won MAX_STREAK times in a row over a waiting fetch.
module svc_rv_mem_arb #(
    parameter int AW         = 10,
    parameter int XLEN       = 32,
    parameter int MAX_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    // instruction side
    input  logic              i_valid,
    input  logic [AW-1:0]     i_addr,
    output logic              i_ready,
    output logic              i_rvalid,
    output logic [XLEN-1:0]   i_rdata,
    // data side
    input  logic              d_valid,
    input  logic              d_we,
    input  logic [AW-1:0]     d_addr,
    input  logic [XLEN-1:0]   d_wdata,
    input  logic [XLEN/8-1:0] d_wstrb,
    output logic              d_ready,
    output logic              d_rvalid,
    output logic [XLEN-1:0]   d_rdata,
    // memory side
    output logic              m_en,
    output logic              m_we,
    output logic [AW-1:0]     m_addr,
    output logic [XLEN-1:0]   m_wdata,
    output logic [XLEN/8-1:0] m_wstrb,
    input  logic [XLEN-1:0]   m_rdata,
    // observability of the fairness counter
    output logic [3:0]        dbg_streak
);

    localparam logic [3:0] STREAK_MAX = 4'(MAX_STREAK);

    // Handshake: a request is granted in a cycle where its valid and ready are both 1.
    // Ready is a pure function of the valids and the streak, never of response state.
    logic [3:0] streak_q, streak_d;
    logic       rsp_i_q, rsp_i_d;
    logic       rsp_d_q, rsp_d_d;
    logic       i_starved;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            streak_q <= 4'd0;
            rsp_i_q  <= 1'b0;
            rsp_d_q  <= 1'b0;
        end else begin
            streak_q <= streak_d;
            rsp_i_q  <= rsp_i_d;
            rsp_d_q  <= rsp_d_d;
        end
    end

    // Grant selection; rst_n gates ready so nothing issues while in reset.
    always_comb begin
        i_starved = i_valid && (streak_q == STREAK_MAX);
        d_ready   = rst_n & d_valid & ~i_starved;
        i_ready   = rst_n & i_valid & ~d_ready;
    end

    always_comb begin
        streak_d = streak_q;
        if (!i_valid || i_ready) begin
            streak_d = 4'd0;
        end else if (d_ready) begin
            streak_d = (streak_q == STREAK_MAX) ? STREAK_MAX : streak_q + 4'd1;
        end
        rsp_i_d = i_ready;
        rsp_d_d = d_ready & ~d_we;
    end

    always_comb begin
        m_en    = i_ready | d_ready;
        m_we    = d_ready & d_we;
        m_addr  = '0;
        m_wdata = '0;
        m_wstrb = '0;
        if (d_ready) begin
            m_addr = d_addr;
        end else if (i_ready) begin
            m_addr = i_addr;
        end
        if (m_we) begin
            m_wdata = d_wdata;
            m_wstrb = d_wstrb;
        end
    end

    // Read data is steered to whichever port owned last cycle's read.
    always_comb begin
        i_rvalid   = rsp_i_q;
        d_rvalid   = rsp_d_q;
        i_rdata    = rsp_i_q ? m_rdata : '0;
        d_rdata    = rsp_d_q ? m_rdata : '0;
        dbg_streak = streak_q;
    end

endmodule

// File: tb/tb_svc_rv_mem_arb.sv
// Directed bench for svc_rv_mem_arb: dut_a uses MAX_STREAK=2, dut_b the default 4.
// Both share the request inputs; each has its own registered memory model.
module tb_svc_rv_mem_arb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_valid, d_valid, d_we;
    logic [9:0]  i_addr, d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wstrb;

    logic        i_ready_a, i_rvalid_a, d_ready_a, d_rvalid_a, m_en_a, m_we_a;
    logic [31:0] i_rdata_a, d_rdata_a, m_wdata_a, m_rdata_a;
    logic [9:0]  m_addr_a;
    logic [3:0]  m_wstrb_a, streak_a;

    logic        i_ready_b, i_rvalid_b, d_ready_b, d_rvalid_b, m_en_b, m_we_b;
    logic [31:0] i_rdata_b, d_rdata_b, m_wdata_b, m_rdata_b;
    logic [9:0]  m_addr_b;
    logic [3:0]  m_wstrb_b, streak_b;

    int tests_run = 0;
    int fails     = 0;

    always #5 clk = ~clk;

    svc_rv_mem_arb #(.AW(10), .XLEN(32), .MAX_STREAK(2)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .i_valid(i_valid), .i_addr(i_addr), .i_ready(i_ready_a),
        .i_rvalid(i_rvalid_a), .i_rdata(i_rdata_a),
        .d_valid(d_valid), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_wstrb(d_wstrb), .d_ready(d_ready_a), .d_rvalid(d_rvalid_a), .d_rdata(d_rdata_a),
        .m_en(m_en_a), .m_we(m_we_a), .m_addr(m_addr_a), .m_wdata(m_wdata_a),
        .m_wstrb(m_wstrb_a), .m_rdata(m_rdata_a), .dbg_streak(streak_a)
    );

    svc_rv_mem_arb #(.AW(10), .XLEN(32), .MAX_STREAK(4)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .i_valid(i_valid), .i_addr(i_addr), .i_ready(i_ready_b),
        .i_rvalid(i_rvalid_b), .i_rdata(i_rdata_b),
        .d_valid(d_valid), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_wstrb(d_wstrb), .d_ready(d_ready_b), .d_rvalid(d_rvalid_b), .d_rdata(d_rdata_b),
        .m_en(m_en_b), .m_we(m_we_b), .m_addr(m_addr_b), .m_wdata(m_wdata_b),
        .m_wstrb(m_wstrb_b), .m_rdata(m_rdata_b), .dbg_streak(streak_b)
    );

    // Memory returns 0xC0DE_0000 | addr one cycle after a read, a marker otherwise.
    always_ff @(posedge clk) begin
        m_rdata_a <= (m_en_a && !m_we_a) ? (32'hC0DE_0000 | 32'(m_addr_a)) : 32'h0BAD_0BAD;
        m_rdata_b <= (m_en_b && !m_we_b) ? (32'hC0DE_0000 | 32'(m_addr_b)) : 32'h0BAD_0BAD;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        i_valid = 1'b0; d_valid = 1'b0; d_we = 1'b0;
        i_addr  = 10'h2AA; d_addr = 10'h155; d_wdata = 32'h1234_5678; d_wstrb = 4'h5;
    endtask

    task automatic drive_i(input logic [9:0] a);
        idle();
        i_valid = 1'b1; i_addr = a;
    endtask

    task automatic drive_d(input logic we, input logic [9:0] a, input logic [31:0] wd,
                           input logic [3:0] ws);
        idle();
        d_valid = 1'b1; d_we = we; d_addr = a; d_wdata = wd; d_wstrb = ws;
    endtask

    logic [5:0] exp_grant_d_a  = 6'b110110;
    logic [3:0] exp_streak_a[6] = '{4'd1, 4'd2, 4'd0, 4'd1, 4'd2, 4'd0};
    logic [4:0] exp_grant_d_b  = 5'b11110;
    logic [3:0] exp_streak_b[5] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0};

    initial begin
        // reset with requests pending: nothing may be granted
        rst_n = 1'b0;
        idle();
        i_valid = 1'b1; d_valid = 1'b1;
        #2;
        chk("rst_i_ready", 32'(i_ready_b), 32'd0);
        chk("rst_d_ready", 32'(d_ready_b), 32'd0);
        chk("rst_m_en", 32'(m_en_b), 32'd0);
        chk("rst_m_we", 32'(m_we_b), 32'd0);
        chk("rst_rvalid", {30'd0, i_rvalid_b, d_rvalid_b}, 32'd0);
        chk("rst_streak", 32'(streak_b), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        tick();

        // instruction fetch alone
        drive_i(10'h010);
        #1;
        chk("if_i_ready", 32'(i_ready_b), 32'd1);
        chk("if_m_en", 32'(m_en_b), 32'd1);
        chk("if_m_addr", 32'(m_addr_b), 32'h010);
        chk("if_m_we", 32'(m_we_b), 32'd0);
        tick();
        idle();
        #1;
        chk("if_i_rvalid", 32'(i_rvalid_b), 32'd1);
        chk("if_i_rdata", i_rdata_b, 32'hC0DE_0010);
        chk("if_d_rvalid", 32'(d_rvalid_b), 32'd0);
        chk("idle_m_en", 32'(m_en_b), 32'd0);
        chk("idle_m_addr", 32'(m_addr_b), 32'd0);
        tick();

        // data write at the top address
        drive_d(1'b1, 10'h3FF, 32'hDEAD_BEEF, 4'hF);
        #1;
        chk("wr_d_ready", 32'(d_ready_b), 32'd1);
        chk("wr_m_we", 32'(m_we_b), 32'd1);
        chk("wr_m_addr", 32'(m_addr_b), 32'h3FF);
        chk("wr_m_wdata", m_wdata_b, 32'hDEAD_BEEF);
        chk("wr_m_wstrb", 32'(m_wstrb_b), 32'hF);
        tick();
        idle();
        #1;
        chk("wr_no_rsp", {30'd0, i_rvalid_b, d_rvalid_b}, 32'd0);
        tick();

        // read then write back-to-back: write issues while the read returns
        drive_d(1'b0, 10'h020, 32'hFFFF_FFFF, 4'hF);
        #1;
        chk("rd_m_wdata_zero", m_wdata_b, 32'd0);
        chk("rd_m_wstrb_zero", 32'(m_wstrb_b), 32'd0);
        tick();
        drive_d(1'b1, 10'h021, 32'hCAFE_F00D, 4'h3);
        #1;
        chk("rw_d_rvalid", 32'(d_rvalid_b), 32'd1);
        chk("rw_d_rdata", d_rdata_b, 32'hC0DE_0020);
        chk("rw_m_we", 32'(m_we_b), 32'd1);
        chk("rw_m_wstrb", 32'(m_wstrb_b), 32'h3);
        tick();
        idle();
        #1;
        chk("rw_after", 32'(d_rvalid_b), 32'd0);

        // alternating owners D, I, D
        drive_d(1'b0, 10'h030, 32'd0, 4'h0);
        tick();
        drive_i(10'h040);
        #1;
        chk("alt1_rv", {30'd0, i_rvalid_b, d_rvalid_b}, 32'b01);
        chk("alt1_data", d_rdata_b, 32'hC0DE_0030);
        tick();
        drive_d(1'b0, 10'h050, 32'd0, 4'h0);
        #1;
        chk("alt2_rv", {30'd0, i_rvalid_b, d_rvalid_b}, 32'b10);
        chk("alt2_data", i_rdata_b, 32'hC0DE_0040);
        tick();
        idle();
        #1;
        chk("alt3_rv", {30'd0, i_rvalid_b, d_rvalid_b}, 32'b01);
        chk("alt3_data", d_rdata_b, 32'hC0DE_0050);
        chk("alt3_i_rdata", i_rdata_b, 32'd0);
        tick();
        #1;
        chk("alt4_rv", {30'd0, i_rvalid_b, d_rvalid_b}, 32'b00);

        // contention on dut_a (cap 2): D,D,I,D,D,I
        for (int k = 0; k < 6; k++) begin
            idle();
            i_valid = 1'b1; i_addr = 10'h100;
            d_valid = 1'b1; d_addr = 10'h200;
            #1;
            chk($sformatf("cont_a_grant%0d", k), {30'd0, i_ready_a, d_ready_a},
                exp_grant_d_a[5-k] ? 32'b01 : 32'b10);
            tick();
            chk($sformatf("cont_a_streak%0d", k), 32'(streak_a), 32'(exp_streak_a[k]));
            chk($sformatf("cont_a_rv%0d", k), {30'd0, i_rvalid_a, d_rvalid_a},
                exp_grant_d_a[5-k] ? 32'b01 : 32'b10);
            chk($sformatf("cont_a_rdata%0d", k), i_rdata_a | d_rdata_a,
                exp_grant_d_a[5-k] ? 32'hC0DE_0200 : 32'hC0DE_0100);
        end

        // dut_b: build streak to 2, drop i_valid once, then count 4 data wins
        idle();
        tick();
        for (int k = 0; k < 2; k++) begin
            idle();
            i_valid = 1'b1; i_addr = 10'h101;
            d_valid = 1'b1; d_addr = 10'h201;
            tick();
        end
        chk("drop_pre_streak", 32'(streak_b), 32'd2);
        drive_d(1'b0, 10'h202, 32'd0, 4'h0);
        tick();
        chk("drop_streak_clr", 32'(streak_b), 32'd0);
        for (int k = 0; k < 5; k++) begin
            idle();
            i_valid = 1'b1; i_addr = 10'h103;
            d_valid = 1'b1; d_addr = 10'h203;
            #1;
            chk($sformatf("cont_b_d_ready%0d", k), 32'(d_ready_b), 32'(exp_grant_d_b[4-k]));
            tick();
            chk($sformatf("cont_b_streak%0d", k), 32'(streak_b), 32'(exp_streak_b[k]));
        end

        // reset right after a contended data read grant
        idle();
        tick();
        i_valid = 1'b1; i_addr = 10'h104;
        d_valid = 1'b1; d_addr = 10'h204;
        @(posedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_d_rvalid", 32'(d_rvalid_b), 32'd0);
        chk("mid_rst_d_rdata", d_rdata_b, 32'd0);
        chk("mid_rst_streak", 32'(streak_b), 32'd0);
        chk("mid_rst_m_en", 32'(m_en_b), 32'd0);
        chk("mid_rst_ready", {30'd0, i_ready_b, d_ready_b}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drive_i(10'h010);
        #1;
        chk("post_rst_rv", {30'd0, i_rvalid_b, d_rvalid_b}, 32'd0);
        chk("post_rst_i_ready", 32'(i_ready_b), 32'd1);
        chk("post_rst_m_addr", 32'(m_addr_b), 32'h010);
        tick();
        idle();
        #1;
        chk("post_rst_i_rvalid", 32'(i_rvalid_b), 32'd1);
        chk("post_rst_i_rdata", i_rdata_b, 32'hC0DE_0010);
        chk("post_rst_d_rvalid", 32'(d_rvalid_b), 32'd0);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

// File: doc/svc_rv_mem_arb.md
SVC_RV_MEM_ARB -- requirements
Module: svc_rv_mem_arb

Interface
REQ-001 SHALL have parameter AW, default 10, meaning word-address width of the shared memory port.
REQ-002 SHALL have parameter XLEN, default 32, meaning data width in bits.
REQ-003 SHALL have parameter MAX_STREAK, default 4 (legal 1..15), meaning the maximum consecutive data grants allowed while an instruction request waits.
REQ-004 SHALL have port clk, input, 1, the single clock; all state on rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-006 SHALL have instruction-side ports: i_valid in 1, i_addr in AW, i_ready out 1, i_rvalid out 1, i_rdata out XLEN.
REQ-007 SHALL have data-side ports: d_valid in 1, d_we in 1, d_addr in AW, d_wdata in XLEN, d_wstrb in XLEN/8, d_ready out 1, d_rvalid out 1, d_rdata out XLEN.
REQ-008 SHALL have memory-side ports: m_en out 1, m_we out 1, m_addr out AW, m_wdata out XLEN, m_wstrb out XLEN/8, m_rdata in XLEN (valid exactly one cycle after a read with m_en=1, m_we=0).

Function
REQ-009 SHALL accept a request on a port in a cycle where valid and ready are both 1 (a grant); at most one grant per cycle.
REQ-010 SHALL grant data over instruction when both are valid, unless streak == MAX_STREAK, in which case instruction is granted.
REQ-011 SHALL drive d_ready = d_valid & ~(i_valid & streak == MAX_STREAK); i_ready = i_valid & ~d_ready; both combinational, no dependence on rvalid outputs.
REQ-012 SHALL hold a streak counter, width 4: on data grant with i_valid=1, increment, saturating at MAX_STREAK; on instruction grant, or any cycle with i_valid=0, clear to 0.
REQ-013 SHALL drive m_en = i_ready | d_ready, m_we = d_ready & d_we, and m_addr/m_wdata/m_wstrb from the granted port; m_wdata/m_wstrb SHALL be 0 when m_we=0.
REQ-014 SHALL, when no port is granted, drive m_en=0, m_we=0, m_addr=0.
REQ-015 SHALL register the read-response owner: rsp_i <= i_ready; rsp_d <= d_ready & ~d_we.
REQ-016 SHALL assert i_rvalid = rsp_i and d_rvalid = rsp_d, exactly one cycle after the corresponding grant; writes SHALL produce no response.
REQ-017 SHALL drive i_rdata = m_rdata when rsp_i, else 0; d_rdata = m_rdata when rsp_d, else 0.
REQ-018 SHALL support back-to-back grants every cycle, including alternating owners; the response of grant N and grant N+1 SHALL appear on consecutive cycles with correct owner.
REQ-019 SHALL never assert i_rvalid and d_rvalid in the same cycle.
REQ-020 SHALL treat a write grant while a read response is returning as independent (write issue and read return coexist in one cycle).
REQ-021 SHALL ignore address/data inputs of a port whose valid is 0.

Reset
REQ-022 SHALL, while rst_n=0, force streak=0, rsp_i=0, rsp_d=0; hence i_rvalid=0, d_rvalid=0, i_rdata=0, d_rdata=0 immediately (asynchronously).
REQ-023 SHALL, while rst_n=0, force i_ready=0, d_ready=0, m_en=0, m_we=0 regardless of valid inputs.
REQ-024 SHALL drop a read response in flight when reset asserts; no rvalid SHALL appear in the first cycle after rst_n deasserts.
REQ-025 SHALL accept new grants in the first rising edge with rst_n=1.

Verification
REQ-026 Bench SHALL cover: i_valid=1 only, i_addr=0x010 -> i_ready=1, m_en=1, m_addr=0x010; next cycle i_rvalid=1, i_rdata=m_rdata.
REQ-027 Bench SHALL cover: MAX_STREAK=2, i_valid and d_valid (reads) held high 6 cycles -> grant order D,D,I,D,D,I; streak 1,2,0,1,2,0.
REQ-028 Bench SHALL cover: d_valid=1, d_we=1, d_addr=0x3FF, d_wdata=0xDEADBEEF, d_wstrb=0xF -> m_we=1, m_addr=0x3FF, m_wdata=0xDEADBEEF; next cycle d_rvalid=0, i_rvalid=0.
REQ-029 Bench SHALL cover: alternating D-read, I-read, D-read on consecutive cycles -> d_rvalid, i_rvalid, d_rvalid on the following three cycles, never overlapping.
REQ-030 Bench SHALL cover: rst_n pulled low mid-cycle right after a data read grant -> d_rvalid stays 0, streak=0, m_en=0 immediately; after release first grant behaves as REQ-026.
REQ-031 Bench SHALL cover: i_valid dropped for one cycle at streak=2 (MAX_STREAK=4) -> streak clears to 0; data wins the next 4 contended cycles before instruction.
